fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter QDEPTH, default 4, instruction queue depth in entries (power of two, 2..16).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, fetch address loaded on reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 redirect  input  1  pulse from execute: discard all fetched/in-flight work, restart at redirectPc.
REQ-006 redirectPc  input  32  new fetch address (jump, jr, bne target).
REQ-007 imReqValid  output  1  instruction-memory read request valid.
REQ-008 imReqAddr  output  32  word address of request.
REQ-009 imReqReady  input  1  memory accepts request this cycle.
REQ-010 imRespValid  input  1  read data returned, in request order, >=1 cycle after acceptance.
REQ-011 imRespData  input  32  returned instruction word.
REQ-012 instrValid  output  1  queue head holds a valid instruction.
REQ-013 instr  output  32  head instruction, to decoder.
REQ-014 instrPc  output  32  address of head instruction.
REQ-015 instrPcInc  output  32  instrPc + 4, for link writes and branch base.
REQ-016 instrReady  input  1  decoder consumes head this cycle.

Function
REQ-017 Request accepted when imReqValid && imReqReady; fetchPc advances by 4 on acceptance, modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-018 imReqAddr SHALL equal fetchPc with bits [1:0] forced to 0.
REQ-019 imReqValid SHALL be 1 only when reset=0, redirect=0, and (queue occupancy + outstanding requests) < QDEPTH.
REQ-020 Each accepted request SHALL push its address into an in-order tag FIFO; each kept response pops it and enqueues {imRespData, address}.
REQ-021 Dequeue when instrValid && instrReady; simultaneous enqueue and dequeue SHALL keep occupancy unchanged, including when full.
REQ-022 instrValid, instr, instrPc, instrPcInc SHALL be driven from registered queue head; no response-to-output bypass; minimum latency request-accept cycle N -> instrValid at N+2.
REQ-023 On redirect: queue emptied, fetchPc := {redirectPc[31:2],2'b00}, discard counter := outstanding requests minus any response arriving that cycle; redirect has priority over simultaneous enqueue, dequeue and request.
REQ-024 While discard counter > 0, each imRespValid SHALL be dropped and decrement the counter; kept responses resume when it reaches 0.
REQ-025 New requests after redirect MAY issue the following cycle while discards are pending; in-order return guarantees stale data precedes new data.
REQ-026 imRespValid with zero outstanding requests SHALL be ignored (no state change).
REQ-027 instrValid SHALL be 0 in the cycle after redirect.

Reset
REQ-028 Reset SHALL set fetchPc=RESET_PC, queue empty, outstanding=0, discard=0; instrValid=0, imReqValid=0 during reset, instr/instrPc/instrPcInc=0.
REQ-029 Reset SHALL override redirect; responses arriving during reset or for pre-reset requests are the memory's responsibility to squash (memory shares reset).

Structure
REQ-030 Shared package fetch_pkg SHALL hold word width (32), default QDEPTH, default RESET_PC, instruction-word increment (4).
REQ-031 One sub-module fetch_queue (synchronous FIFO, data+address, count, full/empty, clear input) SHALL implement the instruction queue; tag FIFO may reuse it.
REQ-032 Counters SHALL be sized clog2(QDEPTH)+1 bits.

Verification
REQ-033 Reset, imReqReady=1, 1-cycle memory, instrReady=1 -> addresses 0,4,8,... issued back-to-back; instrPc 0 at cycle 2 after reset release, then one per cycle, instrPcInc=instrPc+4.
REQ-034 instrReady=0, QDEPTH=4 -> exactly 4 requests accepted, imReqValid stays 0; raising instrReady for one cycle -> exactly one new request.
REQ-035 2 requests outstanding (addr 8,C), redirect to 32'h0000_0103 -> next request addr 0x100; responses for 8,C dropped; first instrPc = 0x100.
REQ-036 Redirect in same cycle as response and dequeue -> queue empty next cycle, discard = outstanding-1, instrValid=0.
REQ-037 RESET_PC=32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; instrPcInc of FFFF_FFFC = 0.
REQ-038 Random imReqReady/imRespValid delays (1-5 cycles) with random redirects -> instrPc stream matches reference sequential model, no duplicate or lost instructions.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, defaults and queue entry type for the fetch unit
package fetch_pkg;
    localparam int WORD_W = 32;
    localparam int DEF_QDEPTH = 4;
    localparam logic [WORD_W-1:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [WORD_W-1:0] INSTR_INC = 32'd4;
    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [WORD_W-1:0] addr;
    } fetch_entry_t;
    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] a);
        return {a[WORD_W-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO with count, full/empty and a clear input
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = DEF_QDEPTH,
    parameter int W     = 2 * WORD_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_clear,
    input  logic                   i_push,
    input  logic [W-1:0]           i_data,
    input  logic                   i_pop,
    output logic [W-1:0]           o_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_cnt;
    logic          w_push;
    logic          w_pop;
    assign o_empty = r_cnt == '0;
    assign o_full  = r_cnt == CW'(DEPTH);
    assign o_count = r_cnt;
    assign o_data  = r_mem[r_rd];
    assign w_pop   = i_pop && !o_empty;
    // a full queue still accepts a push when the head leaves in the same cycle
    assign w_push  = i_push && (!o_full || w_pop);
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop) r_rd <= r_rd + AW'(1);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: issues in-order instruction reads, queues returned words for decode,
// and squashes in-flight responses after a redirect via a discard counter.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                QDEPTH   = DEF_QDEPTH,
    parameter logic [WORD_W-1:0] RESET_PC = DEF_RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirectPc,
    output logic              imReqValid,
    output logic [WORD_W-1:0] imReqAddr,
    input  logic              imReqReady,
    input  logic              imRespValid,
    input  logic [WORD_W-1:0] imRespData,
    output logic              instrValid,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] instrPc,
    output logic [WORD_W-1:0] instrPcInc,
    input  logic              instrReady
);
    localparam int CW = $clog2(QDEPTH) + 1;
    logic [WORD_W-1:0] r_pc;
    logic [CW-1:0]     r_discard;
    logic [CW-1:0]     w_qcnt;
    logic [CW-1:0]     w_tcnt;
    logic [CW-1:0]     w_outst;
    logic [CW:0]       w_inflight;
    logic              w_qfull;
    logic              w_qempty;
    logic              w_tfull;
    logic              w_tempty;
    logic              w_accept;
    logic              w_keep;
    logic              w_deq;
    logic              w_resp_live;
    logic [WORD_W-1:0] w_tag;
    fetch_entry_t      w_head;
    fetch_entry_t      w_entry;
    // outstanding counts both tagged (kept) and to-be-discarded requests in memory
    assign w_outst     = w_tcnt + r_discard;
    assign w_inflight  = {1'b0, w_qcnt} + {1'b0, w_tcnt} + {1'b0, r_discard};
    assign w_resp_live = imRespValid && w_outst != '0;
    assign imReqAddr   = word_align(r_pc);
    assign imReqValid  = !reset && !redirect && !w_qfull && !w_tfull
                         && w_inflight < (CW+1)'(QDEPTH);
    assign w_accept    = imReqValid && imReqReady;
    assign w_keep      = !reset && !redirect && imRespValid && r_discard == '0 && !w_tempty;
    assign w_deq       = instrValid && instrReady && !redirect;
    assign w_entry     = '{data: imRespData, addr: w_tag};
    assign instrValid  = !reset && !w_qempty;
    assign instr       = instrValid ? w_head.data : '0;
    assign instrPc     = instrValid ? w_head.addr : '0;
    assign instrPcInc  = instrValid ? w_head.addr + INSTR_INC : '0;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc      <= word_align(RESET_PC);
            r_discard <= '0;
        end else if (redirect) begin
            r_pc      <= word_align(redirectPc);
            r_discard <= w_outst - CW'(w_resp_live);
        end else begin
            if (w_accept) r_pc <= r_pc + INSTR_INC;
            if (imRespValid && r_discard != '0) r_discard <= r_discard - CW'(1);
        end
    end
    fetch_queue #(.DEPTH(QDEPTH), .W(WORD_W)) u_tags (
        .clk     (clk),
        .reset   (reset),
        .i_clear (redirect),
        .i_push  (w_accept),
        .i_data  (imReqAddr),
        .i_pop   (w_keep),
        .o_data  (w_tag),
        .o_count (w_tcnt),
        .o_full  (w_tfull),
        .o_empty (w_tempty)
    );
    fetch_queue #(.DEPTH(QDEPTH), .W(2 * WORD_W)) u_iq (
        .clk     (clk),
        .reset   (reset),
        .i_clear (redirect),
        .i_push  (w_keep),
        .i_data  (w_entry),
        .i_pop   (w_deq),
        .o_data  (w_head),
        .o_count (w_qcnt),
        .o_full  (w_qfull),
        .o_empty (w_qempty)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against an
// in-order memory model and a sequential program-counter reference.
module tb_fetch_unit;
    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;
    logic        clk = 0;
    logic        reset = 1;
    logic        redirect = 0;
    logic [31:0] redirectPc = 0;
    logic        imReqReady = 0;
    logic        imRespValid = 0;
    logic [31:0] imRespData = 0;
    logic        instrReady = 0;
    logic        imReqValid;
    logic [31:0] imReqAddr;
    logic        instrValid;
    logic [31:0] instr;
    logic [31:0] instrPc;
    logic [31:0] instrPcInc;
    logic        imReqValid2;
    logic [31:0] imReqAddr2;
    logic        imRespValid2 = 0;
    logic [31:0] imRespData2 = 0;
    logic        instrValid2;
    logic [31:0] instr2;
    logic [31:0] instrPc2;
    logic [31:0] instrPcInc2;
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int nacc = 0;
    int ndeq = 0;
    int lat_lo = 1;
    int lat_hi = 1;
    int rdy_pct = 100;
    int spur_pct = 0;
    bit hold = 0;
    bit acc2_prev = 0;
    logic [31:0] addr2_prev = 0;
    logic [31:0] exp_pc = 0;
    req_t pend[$];

    always #5 clk = ~clk;

    fetch_unit u_dut (
        .clk(clk), .reset(reset), .redirect(redirect), .redirectPc(redirectPc),
        .imReqValid(imReqValid), .imReqAddr(imReqAddr), .imReqReady(imReqReady),
        .imRespValid(imRespValid), .imRespData(imRespData),
        .instrValid(instrValid), .instr(instr), .instrPc(instrPc),
        .instrPcInc(instrPcInc), .instrReady(instrReady)
    );

    fetch_unit #(.QDEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_dut2 (
        .clk(clk), .reset(reset), .redirect(1'b0), .redirectPc(32'h0),
        .imReqValid(imReqValid2), .imReqAddr(imReqAddr2), .imReqReady(1'b1),
        .imRespValid(imRespValid2), .imRespData(imRespData2),
        .instrValid(instrValid2), .instr(instr2), .instrPc(instrPc2),
        .instrPcInc(instrPcInc2), .instrReady(1'b1)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        assert (act === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    // one clock cycle: drive inputs at negedge, let the memory answer in order, then sample
    task automatic step(input bit rst, input bit rd, input logic [31:0] rpc, input bit ir);
        @(negedge clk);
        cyc++;
        reset = rst;
        redirect = rd;
        redirectPc = rpc;
        instrReady = ir;
        imReqReady = ($urandom_range(0, 99) < rdy_pct);
        imRespValid = 0;
        imRespData = $urandom;
        if (rst) pend.delete();
        else if (!hold && pend.size() > 0 && pend[0].due <= cyc) begin
            imRespValid = 1;
            imRespData = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else if (pend.size() == 0 && $urandom_range(0, 99) < spur_pct) imRespValid = 1;
        imRespValid2 = acc2_prev && !rst;
        imRespData2 = mem_word(addr2_prev);
        #1;
        acc2_prev = imReqValid2;
        addr2_prev = imReqAddr2;
        if (rst || rd) chk("req_blocked", {31'b0, imReqValid}, 0);
        if (rst) exp_pc = 0;
        else if (rd) exp_pc = {rpc[31:2], 2'b00};
        else if (instrValid && ir) begin
            chk("stream_pc", instrPc, exp_pc);
            chk("stream_instr", instr, mem_word(exp_pc));
            chk("stream_pcinc", instrPcInc, exp_pc + 4);
            exp_pc = exp_pc + 4;
            ndeq++;
        end
        if (imReqValid && imReqReady) begin
            nacc++;
            pend.push_back('{imReqAddr, cyc + int'($urandom_range(lat_lo, lat_hi))});
        end
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
    endtask

    task automatic wait_first(input logic [31:0] target);
        int n = 0;
        while (!instrValid && n < 20) begin
            step(0, 0, 0, 1);
            n++;
        end
        chk("first_valid", {31'b0, instrValid}, 1);
        chk("first_pc", instrPc, target);
    endtask

    initial begin
        do_reset();
        chk("rst_valid", {31'b0, instrValid}, 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", instrPc, 0);
        chk("rst_pcinc", instrPcInc, 0);
        chk("rst_valid2", {31'b0, instrValid2}, 0);
        // back-to-back fetch with a one-cycle memory, plus wrap-around instance
        for (int k = 0; k < 8; k++) begin
            step(0, 0, 0, 1);
            chk("seq_addr", imReqAddr, 32'(4 * k));
            chk("seq_valid", {31'b0, instrValid}, {31'b0, k >= 2});
            chk("wrap_addr", imReqAddr2, 32'hFFFF_FFF8 + 32'(4 * k));
            if (k >= 2) begin
                chk("seq_pc", instrPc, 32'(4 * (k - 2)));
                chk("wrap_pc", instrPc2, 32'hFFFF_FFF8 + 32'(4 * (k - 2)));
                chk("wrap_pcinc", instrPcInc2, 32'hFFFF_FFFC + 32'(4 * (k - 2)));
            end
        end
        // stalled decoder: queue plus in-flight capped at four
        do_reset();
        nacc = 0;
        for (int k = 0; k < 10; k++) step(0, 0, 0, 0);
        chk("stall_accepts", nacc, 4);
        chk("stall_reqvalid", {31'b0, imReqValid}, 0);
        chk("stall_full_valid", {31'b0, instrValid}, 1);
        step(0, 0, 0, 1);
        nacc = 0;
        for (int k = 0; k < 8; k++) step(0, 0, 0, 0);
        chk("one_slot_accepts", nacc, 1);
        // redirect with two requests (8, C) still in memory
        do_reset();
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0);
        hold = 1;
        step(0, 0, 0, 0);
        step(0, 1, 32'h0000_0103, 0);
        hold = 0;
        step(0, 0, 0, 1);
        chk("redir_valid", {31'b0, instrValid}, 0);
        chk("redir_reqvalid", {31'b0, imReqValid}, 1);
        chk("redir_addr", imReqAddr, 32'h100);
        wait_first(32'h100);
        // redirect coinciding with a response and a dequeue
        do_reset();
        lat_lo = 2;
        lat_hi = 2;
        for (int k = 0; k < 6; k++) step(0, 0, 0, 1);
        step(0, 1, 32'h40, 1);
        chk("coinc_valid_before", {31'b0, instrValid}, 1);
        step(0, 0, 0, 1);
        chk("coinc_valid_after", {31'b0, instrValid}, 0);
        wait_first(32'h40);
        // random memory timing, stalls, spurious responses and redirects
        do_reset();
        lat_lo = 1;
        lat_hi = 5;
        rdy_pct = 70;
        spur_pct = 10;
        ndeq = 0;
        for (int i = 0; i < 3000; i++)
            step(0, $urandom_range(0, 39) == 0, $urandom, $urandom_range(0, 3) != 0);
        chk("rand_progress", {31'b0, ndeq > 300}, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
